// File: rtl/ysyx_23060221_mem_arbiter.sv
// Two-master, one-slave memory arbiter (IFU = master 0, LSU = master 1).
// One outstanding transaction, round-robin grant, response timeout with
// stale-beat discard so a late memory response cannot be handed to the
// wrong transaction.
`timescale 1ns/1ps
module ysyx_23060221_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (instruction fetch, read-only)
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_req_addr,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  // master 1 (load/store)
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_req_addr,
  input  logic        m1_req_wen,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_wmask,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  // slave (memory)
  output logic        s_req_valid,
  input  logic        s_req_ready,
  output logic [31:0] s_req_addr,
  output logic        s_req_wen,
  output logic [31:0] s_req_wdata,
  output logic [3:0]  s_req_wmask,
  input  logic        s_rsp_valid,
  output logic        s_rsp_ready,
  input  logic [31:0] s_rsp_rdata,
  output logic        grant
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        stale_q, stale_d;
  logic [31:0] cnt_q, cnt_d;

  logic        any_req;
  logic        sel;
  logic        rsp_taken;

  // Round-robin winner: a lone requester wins, a tie goes to the master
  // that was not granted last.
  always_comb begin
    any_req = m0_req_valid | m1_req_valid;
    if (m0_req_valid && m1_req_valid) begin
      sel = ~grant_q;
    end else begin
      sel = m1_req_valid;
    end
    rsp_taken = grant_q ? m1_rsp_ready : m0_rsp_ready;
  end

  // Next-state, request capture, response capture and timeout handling.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    stale_d      = stale_q;
    cnt_d        = cnt_q;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          m0_req_ready = ~sel;
          m1_req_ready = sel;
          grant_d      = sel;
          if (sel) begin
            addr_d  = m1_req_addr;
            wen_d   = m1_req_wen;
            wdata_d = m1_req_wdata;
            wmask_d = m1_req_wmask;
          end else begin
            addr_d  = m0_req_addr;
            wen_d   = 1'b0;
            wdata_d = 32'h0;
            wmask_d = 4'h0;
          end
          state_d = StReq;
        end
      end
      StReq: begin
        if (s_req_ready) begin
          cnt_d   = 32'h0;
          state_d = StRsp;
        end
      end
      StRsp: begin
        cnt_d = cnt_q + 32'd1;
        if (s_rsp_valid && !stale_q) begin
          rdata_d = wen_q ? 32'h0 : s_rsp_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else begin
          // A beat while stale belongs to an earlier timed-out request.
          if (s_rsp_valid) begin
            stale_d = 1'b0;
          end
          if ((TIMEOUT != 0) && (cnt_d == TIMEOUT)) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            stale_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (rsp_taken) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant_q <= 1'b1;
      addr_q  <= 32'h0;
      wen_q   <= 1'b0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs decoded from state; response fields shared by both masters.
  always_comb begin
    s_req_valid  = (state_q == StReq);
    s_rsp_ready  = (state_q == StRsp);
    s_req_addr   = addr_q;
    s_req_wen    = wen_q;
    s_req_wdata  = wdata_q;
    s_req_wmask  = wmask_q;
    m0_rsp_valid = (state_q == StDone) && !grant_q;
    m1_rsp_valid = (state_q == StDone) && grant_q;
    m0_rsp_rdata = rdata_q;
    m1_rsp_rdata = rdata_q;
    m0_rsp_err   = err_q;
    m1_rsp_err   = err_q;
    grant        = grant_q;
  end

endmodule
